// File: rtl/parity_pkg.sv
// Shared constants and state encoding for the parity frame arbiter and its
// parity generator.
package parity_pkg;

  localparam int PAR_DATA_W = 16;
  localparam int CNT_W      = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/parity_frame_arbiter_if.sv
// Requester-side and consumer-side handshake bundle of the parity frame arbiter.
// Handshake rule: a transfer happens on a rising clk edge where valid && ready;
// a producer keeps valid and payload stable until that edge.
interface parity_frame_arbiter_if #(
  parameter int NREQ = 2
);
  import parity_pkg::*;

  localparam int SRC_W = $clog2(NREQ);

  logic [NREQ-1:0]            req_valid;
  logic [NREQ*PAR_DATA_W-1:0] req_data;
  logic [NREQ-1:0]            req_last;
  logic [NREQ-1:0]            req_ready;

  logic                  out_valid;
  logic [PAR_DATA_W-1:0] out_data;
  logic                  out_par;
  logic [SRC_W-1:0]      out_src;
  logic                  out_last;
  logic                  out_frame_par;
  logic                  out_ready;

  logic busy;
  logic err_overlen;

  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_par, out_src, out_last,
           out_frame_par, busy, err_overlen
  );

  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_par, out_src, out_last,
           out_frame_par, busy, err_overlen
  );

endinterface

// File: rtl/parity_generator.sv
// Combinational even-parity generator: par_out is 1 when data_in has an odd
// number of ones.
module parity_generator
  import parity_pkg::*;
(
  input  logic [PAR_DATA_W-1:0] data_in,
  output logic                  par_out
);

  assign par_out = ^data_in;

endmodule

// File: rtl/parity_frame_arbiter.sv
// Round-robin frame arbiter sharing one parity generator among NREQ word
// producers; emits each word with its parity, source and running frame parity.
module parity_frame_arbiter
  import parity_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int MAX_FRAME = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  parity_frame_arbiter_if.slave   bus,
  output state_t                  state_dbg
);

  localparam int SRC_W = $clog2(NREQ);

  state_t                state;
  logic [SRC_W-1:0]      gnt;
  logic [SRC_W-1:0]      ptr;
  logic [CNT_W-1:0]      cnt;
  logic                  acc;

  logic                  out_valid_r;
  logic [PAR_DATA_W-1:0] out_data_r;
  logic                  out_par_r;
  logic [SRC_W-1:0]      out_src_r;
  logic                  out_last_r;
  logic                  out_frame_par_r;
  logic                  err_r;

  logic [PAR_DATA_W-1:0] word;
  logic                  word_par;
  logic                  gnt_valid;
  logic                  gnt_last;
  logic                  slot_free;
  logic                  accept;
  logic [CNT_W:0]        cnt_inc;
  logic                  at_limit;
  logic                  frame_end;
  logic [SRC_W-1:0]      gnt_next;
  logic [NREQ-1:0]       ready;

  // First requesting index at or after start, wrapping modulo NREQ.
  function automatic logic [SRC_W-1:0] rr_pick(input logic [NREQ-1:0] reqs,
                                               input logic [SRC_W-1:0] start);
    logic [SRC_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(start) + i) % NREQ;
      for (int j = 0; j < NREQ; j++) begin
        if (!found && j == idx && reqs[j]) begin
          pick  = SRC_W'(j);
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

  always_comb begin
    word      = '0;
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt == SRC_W'(i)) begin
        word      = bus.req_data[i*PAR_DATA_W +: PAR_DATA_W];
        gnt_valid = bus.req_valid[i];
        gnt_last  = bus.req_last[i];
      end
    end
  end

  parity_generator u_par (
    .data_in (word),
    .par_out (word_par)
  );

  // The output register can take a new word when empty or draining this cycle.
  assign slot_free = !out_valid_r || bus.out_ready;
  assign accept    = (state == STREAM) && gnt_valid && slot_free;
  assign cnt_inc   = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign at_limit  = (cnt_inc == (CNT_W+1)'(MAX_FRAME));
  assign frame_end = gnt_last || at_limit;
  assign gnt_next  = (gnt == SRC_W'(NREQ-1)) ? '0 : gnt + 1'b1;

  always_comb begin
    ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (state == STREAM && gnt == SRC_W'(i)) ready[i] = slot_free;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      gnt             <= '0;
      ptr             <= '0;
      cnt             <= '0;
      acc             <= 1'b0;
      out_valid_r     <= 1'b0;
      out_data_r      <= '0;
      out_par_r       <= 1'b0;
      out_src_r       <= '0;
      out_last_r      <= 1'b0;
      out_frame_par_r <= 1'b0;
      err_r           <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            gnt   <= rr_pick(bus.req_valid, ptr);
            state <= STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            if (frame_end) begin
              cnt   <= '0;
              acc   <= 1'b0;
              ptr   <= gnt_next;
              state <= IDLE;
            end else begin
              cnt <= cnt_inc[CNT_W-1:0];
              acc <= acc ^ word_par;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        out_valid_r     <= 1'b1;
        out_data_r      <= word;
        out_par_r       <= word_par;
        out_src_r       <= gnt;
        out_last_r      <= frame_end;
        out_frame_par_r <= acc ^ word_par;
        // A limit hit that coincides with req_last is an ordinary frame end.
        err_r           <= at_limit && !gnt_last;
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign bus.req_ready     = ready;
  assign bus.out_valid     = out_valid_r;
  assign bus.out_data      = out_data_r;
  assign bus.out_par       = out_par_r;
  assign bus.out_src       = out_src_r;
  assign bus.out_last      = out_last_r;
  assign bus.out_frame_par = out_frame_par_r;
  assign bus.busy          = (state == STREAM);
  assign bus.err_overlen   = err_r;
  assign state_dbg         = state;

endmodule

// File: tb/tb_parity_frame_arbiter.sv
// Self-checking bench for parity_frame_arbiter: directed scenarios plus random
// traffic scored against a per-source frame/parity reference model.
module tb_parity_frame_arbiter;
  import parity_pkg::*;

  localparam int NREQ = 2;
  localparam int MAXF = 4;

  logic   clk;
  logic   rst;
  logic   out_ready;
  logic   rv [NREQ];
  logic   rl [NREQ];
  logic [15:0] rd [NREQ];
  state_t state_dbg;

  parity_frame_arbiter_if #(.NREQ(NREQ)) bus ();

  assign bus.req_valid = {rv[1], rv[0]};
  assign bus.req_last  = {rl[1], rl[0]};
  assign bus.req_data  = {rd[1], rd[0]};
  assign bus.out_ready = out_ready;

  parity_frame_arbiter #(.NREQ(NREQ), .MAX_FRAME(MAXF)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- bench state ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int valid_pct = 100;
  int ready_pct = 100;
  int stall_req = 0;
  int stall_cycles = 0;
  int err_pulses = 0;
  int acc_cnt [NREQ];
  logic acc_pend [NREQ];

  logic [16:0] src_q0 [$];
  logic [16:0] src_q1 [$];
  logic [19:0] exp_q0 [$];
  logic [19:0] exp_q1 [$];
  int seg_cnt [NREQ];
  logic seg_acc [NREQ];

  int hs_log [$];
  int frame_log [$];
  logic held;
  logic [31:0] snap;
  logic prev_last;
  logic prev_src;
  logic err_flag;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pack_out();
    return {11'b0, bus.out_valid, bus.out_data, bus.out_par, bus.out_src,
            bus.out_last, bus.out_frame_par};
  endfunction

  // Reference model: per-source segmentation into frames of at most MAXF words.
  task automatic push_word(input int i, input logic [15:0] d, input logic l);
    logic p, e_end, e_err;
    logic [19:0] entry;
    p = (($countones(d) % 2) == 1);
    seg_cnt[i]++;
    seg_acc[i] = seg_acc[i] ^ p;
    e_end = l || (seg_cnt[i] == MAXF);
    e_err = e_end && !l;
    entry = {e_err, seg_acc[i], e_end, p, d};
    if (i == 0) begin src_q0.push_back({l, d}); exp_q0.push_back(entry); end
    else        begin src_q1.push_back({l, d}); exp_q1.push_back(entry); end
    if (e_end) begin seg_cnt[i] = 0; seg_acc[i] = 1'b0; end
  endtask

  task automatic clear_logs();
    hs_log.delete();
    frame_log.delete();
    stall_cycles = 0;
    err_pulses = 0;
    acc_cnt[0] = 0;
    acc_cnt[1] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      rv[i] = 1'b0; rl[i] = 1'b0; rd[i] = '0;
      acc_pend[i] = 1'b0; seg_cnt[i] = 0; seg_acc[i] = 1'b0;
    end
    src_q0.delete(); src_q1.delete(); exp_q0.delete(); exp_q1.delete();
    held = 1'b0; prev_last = 1'b1; prev_src = 1'b0; err_flag = 1'b0;
    @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_out_par", 32'(bus.out_par), 0);
    check("rst_out_src", 32'(bus.out_src), 0);
    check("rst_out_last", 32'(bus.out_last), 0);
    check("rst_out_frame_par", 32'(bus.out_frame_par), 0);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_err_overlen", 32'(bus.err_overlen), 0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- driver + monitor, one clock per call ----------------
  task automatic cycle();
    logic [19:0] e;
    logic [31:0] cur;
    logic        have;
    @(negedge clk);
    if (acc_pend[0]) begin void'(src_q0.pop_front()); rv[0] = 1'b0; acc_pend[0] = 1'b0; end
    if (acc_pend[1]) begin void'(src_q1.pop_front()); rv[1] = 1'b0; acc_pend[1] = 1'b0; end
    if (!rv[0] && src_q0.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
      rv[0] = 1'b1; {rl[0], rd[0]} = src_q0[0];
    end
    if (!rv[1] && src_q1.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
      rv[1] = 1'b1; {rl[1], rd[1]} = src_q1[0];
    end
    if (stall_req > 0) begin out_ready = 1'b0; stall_req--; end
    else out_ready = ($urandom_range(0, 99) < ready_pct);
    #4;
    cur = pack_out();
    if (bus.err_overlen) begin err_flag = 1'b1; err_pulses++; end
    if (held) check("hold", cur, snap);
    if (bus.out_valid && !out_ready) begin
      stall_cycles++;
      check("stall_ready", 32'(bus.req_ready), 0);
    end
    check("ready_onehot", 32'($countones(bus.req_ready) <= 1), 1);
    if (bus.out_valid && out_ready) begin
      if (!prev_last) check("frame_src", 32'(bus.out_src), 32'(prev_src));
      have = 1'b0;
      e = '0;
      if (bus.out_src == 1'b0 && exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
      if (bus.out_src == 1'b1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
      check("exp_avail", 32'(have), 1);
      check("word", {12'b0, err_flag, bus.out_frame_par, bus.out_last, bus.out_par, bus.out_data},
            {12'b0, e});
      prev_last = bus.out_last;
      prev_src  = bus.out_src;
      hs_log.push_back(cyc);
      if (bus.out_last) frame_log.push_back(int'(bus.out_src));
      err_flag = 1'b0;
    end
    held = bus.out_valid && !out_ready;
    snap = cur;
    for (int i = 0; i < NREQ; i++) begin
      acc_pend[i] = rv[i] && bus.req_ready[i];
      if (acc_pend[i]) acc_cnt[i]++;
    end
    cyc++;
  endtask

  task automatic run_drain(input string tag, input int budget);
    int n = 0;
    while ((src_q0.size() + src_q1.size() + exp_q0.size() + exp_q1.size()) > 0 && n < budget) begin
      cycle();
      n++;
    end
    check({tag, "_drained"}, 32'(n < budget), 1);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int start;
    int n;
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      rv[i] = 1'b0; rl[i] = 1'b0; rd[i] = '0; acc_pend[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    do_reset();

    // single frame: pars 0,1,0, frame parity 1, back-to-back outputs
    clear_logs();
    valid_pct = 100; ready_pct = 100;
    start = cyc;
    push_word(0, 16'h0000, 1'b0);
    push_word(0, 16'h0001, 1'b0);
    push_word(0, 16'h0003, 1'b1);
    run_drain("single", 50);
    check("single_words", 32'(hs_log.size()), 3);
    if (hs_log.size() == 3) begin
      check("single_latency", 32'(hs_log[0] - start), 2);
      check("single_back2back", 32'(hs_log[2] - hs_log[0]), 2);
    end
    check("single_frames", 32'(frame_log.size()), 1);

    // simultaneous requests after reset: source 0 first, one idle cycle between
    do_reset();
    clear_logs();
    push_word(0, 16'h8001, 1'b1);
    push_word(1, 16'h0007, 1'b1);
    run_drain("simul", 50);
    check("simul_frames", 32'(frame_log.size()), 2);
    if (frame_log.size() == 2) begin
      check("simul_first_src", 32'(frame_log[0]), 0);
      check("simul_second_src", 32'(frame_log[1]), 1);
    end
    if (hs_log.size() == 2) check("simul_gap", 32'(hs_log[1] - hs_log[0]), 2);

    // backpressure: 3-cycle stall after the second output word
    clear_logs();
    for (int k = 0; k < 4; k++) push_word(0, 16'($urandom), k == 3);
    n = 0;
    while (hs_log.size() < 2 && n < 50) begin cycle(); n++; end
    check("bp_reach", 32'(hs_log.size()), 2);
    stall_req = 3;
    run_drain("bp", 50);
    check("bp_stalls", 32'(stall_cycles), 3);
    check("bp_words", 32'(hs_log.size()), 4);

    // overlength: six words without last, limit four
    do_reset();
    clear_logs();
    for (int k = 0; k < 6; k++) push_word(0, 16'h0001, 1'b0);
    run_drain("ovl", 100);
    check("ovl_words", 32'(hs_log.size()), 6);
    check("ovl_frames", 32'(frame_log.size()), 1);
    check("ovl_err_pulses", 32'(err_pulses), 1);
    check("ovl_busy", 32'(bus.busy), 1);

    // reset after two of four words, then a clean one-word frame
    do_reset();
    clear_logs();
    for (int k = 0; k < 4; k++) push_word(0, 16'($urandom), k == 3);
    n = 0;
    while (acc_cnt[0] < 2 && n < 50) begin cycle(); n++; end
    check("mid_accepts", 32'(acc_cnt[0]), 2);
    do_reset();
    clear_logs();
    push_word(0, 16'h0001, 1'b1);
    run_drain("mid_after", 50);
    check("mid_after_frames", 32'(frame_log.size()), 1);

    // fairness: sources alternate 1,0,1,0
    do_reset();
    clear_logs();
    for (int f = 0; f < 2; f++) begin
      push_word(1, 16'($urandom), 1'b0);
      push_word(1, 16'($urandom), 1'b1);
    end
    cycle();
    for (int f = 0; f < 2; f++) begin
      push_word(0, 16'($urandom), 1'b0);
      push_word(0, 16'($urandom), 1'b1);
    end
    run_drain("fair", 100);
    check("fair_frames", 32'(frame_log.size()), 4);
    if (frame_log.size() == 4) begin
      for (int k = 0; k < 4; k++) check("fair_src", 32'(frame_log[k]), 32'((k % 2 == 0) ? 1 : 0));
    end

    // random traffic with random gaps and backpressure
    do_reset();
    clear_logs();
    valid_pct = 70; ready_pct = 70;
    for (int f = 0; f < 40; f++) begin
      int src;
      int len;
      src = $urandom_range(0, 1);
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) push_word(src, 16'($urandom), k == len - 1);
    end
    run_drain("rand", 6000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_frame_arbiter.md
# parity_frame_arbiter

Shares one 16-bit `parity_generator` among `NREQ` requesters that each send frames of words. The block grants one requester at a time, round-robin, for the length of a whole frame. Each accepted word goes through the shared generator. The block returns the word, its parity bit and the source index, and closes each frame with the accumulated frame parity. It sits between the word producers and any consumer of parity-tagged data.

## Interface
Parameters:
- `NREQ`, 2: number of requesters, 2..8.
- `MAX_FRAME`, 255: maximum words per frame, 1..255. Word counter is 8 bits.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester word valid.
- `req_data`  in  NREQ*16  per-requester word; requester i uses bits [16i+15:16i].
- `req_last`  in  NREQ  marks the final word of requester i's frame.
- `req_ready`  out  NREQ  per-requester accept; at most one bit is high.
- `out_valid`  out  1  result word valid.
- `out_data`  out  16  accepted word.
- `out_par`  out  1  XOR of `out_data` bits, i.e. 1 when the count of ones is odd.
- `out_src`  out  $clog2(NREQ)  index of the requester that sent the word.
- `out_last`  out  1  final word of the frame, including forced termination.
- `out_frame_par`  out  1  XOR of all word parities in the frame so far; meaningful when `out_last`=1.
- `out_ready`  in  1  consumer accepts the result.
- `busy`  out  1  high while in STREAM.
- `err_overlen`  out  1  one-cycle pulse when a frame is force-terminated at `MAX_FRAME`.

## Operation
States: IDLE and STREAM.

IDLE:
- If any `req_valid` is high, grant the first requester found scanning from `ptr` upward, wrapping modulo `NREQ`.
- Register the grant in `gnt` and go to STREAM.
- `req_ready` is all zero in IDLE.

STREAM:
- `req_ready[gnt] = !out_valid || out_ready`. All other bits are 0.
- A word is accepted when `req_valid[gnt] && req_ready[gnt]`. On accept:
  - `out_data` ← word.
  - `out_par` ← `par_out` of the generator, whose `data_in` is the granted word.
  - `out_src` ← `gnt`.
  - `acc` ← `acc ^ par`; `out_frame_par` ← `acc ^ par`.
  - `cnt` ← `cnt + 1`.
- Frame end on accept, when `req_last[gnt]` is high or `cnt+1 == MAX_FRAME`:
  - `out_last`=1.
  - `acc` and `cnt` clear to 0.
  - `ptr` ← (`gnt`+1) mod `NREQ`.
  - Go to IDLE.
- If the frame ends on the `MAX_FRAME` limit without `req_last`:
  - `err_overlen` pulses in the same cycle that `out_valid` rises for that word.
  - The requester's remaining words form a new frame after re-arbitration.
- `req_last` with `cnt+1 == MAX_FRAME` is a normal end; no error.
- A granted requester that drops `req_valid` mid-frame keeps the grant. There is no timeout.

Output register:
- `out_valid` clears when `out_ready` is high and no new word is accepted that cycle.
- All `out_*` fields hold while `out_valid && !out_ready`.

Simultaneous events:
- A requester that raises `req_valid` during another requester's frame waits for that frame's end.
- Accepting a new word and draining the previous one in the same cycle is allowed, giving 1 word/cycle.

## Timing
- Reset values: `out_valid` 0, `out_data` 0, `out_par` 0, `out_src` 0, `out_last` 0, `out_frame_par` 0, `req_ready` 0, `busy` 0, `err_overlen` 0. Internally `ptr` 0, `gnt` 0, `cnt` 0, `acc` 0, state IDLE.
- `rst` asserted mid-frame discards the frame. No `out_last` is produced, and the next frame's parity is unaffected.
- `req_valid` seen in IDLE at cycle t gives STREAM at t+1. The first word can be accepted at t+1, and `out_valid` is high at t+2.
- Latency is 1 cycle from accept to `out_valid`.
- Within a frame, throughput is 1 word/cycle while `out_ready`=1.
- Between frames there is exactly one IDLE arbitration cycle.
- `req_ready` depends combinationally on `out_ready`. It is not registered.

## Structure
- Shared package `parity_pkg` holds:
  - `PAR_DATA_W` = 16.
  - State enum `{IDLE, STREAM}`.
  - `CNT_W` = 8.
- One sub-module: the existing `parity_generator` (`data_in` [15:0], `par_out`), instantiated once. Its input is muxed from the granted requester.
- The round-robin pick is a function inside the block, not a separate module.

## Test plan
- **Single frame:** `NREQ`=2. Requester 0 sends 0x0000, 0x0001, 0x0003 with last on the third word, `out_ready`=1. Required: `out_par` 0, 1, 0; `out_src` 0; `out_last` only on the third word; `out_frame_par`=1; output words on consecutive cycles.
- **Simultaneous requests after reset:** both requesters send one-word frames, 0x8001 and 0x0007. Required: source 0 is served first with par 0; then, after one idle cycle, source 1 with par 1 and `out_frame_par` 1.
- **Backpressure:** `out_ready`=0 for 3 cycles mid-frame. Required: `out_*` held stable, `req_ready`=0, no word lost or duplicated, and the sequence resumes in order.
- **Overlength:** `MAX_FRAME`=4, requester 0 sends 6 words of 0x0001 with no last. Required:
  - Word 4 has `out_last`=1, `err_overlen` pulses, and `out_frame_par`=0.
  - Words 5 and 6 follow as a new frame after re-arbitration.
- **Reset mid-frame:** assert `rst` after 2 of 4 words. Required: every output is 0 the next cycle and state is IDLE. A following one-word frame of 0x0001 gives `out_frame_par`=1.
- **Fairness:** requester 1 sends back-to-back 2-word frames while requester 0 raises `req_valid`. Required: sources alternate frame by frame, 1, 0, 1, 0.
